// File: rtl/fifo_drain_if.sv
// Bus bundle between the FIFO read port, the drain stage and the downstream sink.
// The master modport is the drain stage. The slave modport is its environment,
// meaning the FIFO plus the sink.
interface fifo_drain_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 11
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0]  drained_cnt;

  modport master (
    input  fifo_empty, fifo_dout, out_ready,
    output fifo_rd, out_valid, out_data, drained_cnt
  );

  modport slave (
    output fifo_empty, fifo_dout, out_ready,
    input  fifo_rd, out_valid, out_data, drained_cnt
  );
endinterface

// File: rtl/fifo_drain.sv
// Read-side drain stage for a FIFO with 1-cycle read latency.
// Words are popped into a 2-entry skid buffer and presented on a valid/ready stream.
// The stage keeps a wrapping count of delivered words.
module fifo_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 11
) (
  input  logic          clk,
  input  logic          resetn,
  fifo_drain_if.master  bus
);

  // Skid state. Entry 0 is the head, and it is what out_data shows.
  logic [1:0]            occ;
  logic                  pend;
  logic [DATA_WIDTH-1:0] entry0;
  logic [DATA_WIDTH-1:0] entry1;
  logic                  valid_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  // Next-state values.
  logic [1:0]            occ_nxt;
  logic [DATA_WIDTH-1:0] e0_nxt;
  logic [DATA_WIDTH-1:0] e1_nxt;

  logic                  xfer;
  logic                  rd;
  logic [2:0]            level;

  // Count every slot that is in use, including a read still in flight.
  // The word leaving this cycle is subtracted, because its slot frees up.
  // A pop is issued only while this projected level stays below 2.
  // As a result, occ + pend never exceeds 2 and the buffer cannot overflow.
  assign xfer  = valid_q & bus.out_ready;
  assign level = {1'b0, occ} + {2'b00, pend} - {2'b00, xfer};
  assign rd    = resetn & ~bus.fifo_empty & (level < 3'd2);

  assign bus.fifo_rd     = rd;
  assign bus.out_valid   = valid_q;
  assign bus.out_data    = entry0;
  assign bus.drained_cnt = cnt_q;

  // Skid buffer update. pend is the write and xfer is the read.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
    occ_nxt = occ;
    e0_nxt  = entry0;
    e1_nxt  = entry1;
    case ({pend, xfer})
      2'b10: begin
        if (occ == 2'd0) e0_nxt = bus.fifo_dout;
        else             e1_nxt = bus.fifo_dout;
        occ_nxt = occ + 2'd1;
      end
      2'b01: begin
        e0_nxt  = entry1;
        occ_nxt = occ - 2'd1;
      end
      2'b11: begin
        if (occ == 2'd1) begin
          e0_nxt = bus.fifo_dout;
        end else begin
          e0_nxt = entry1;
          e1_nxt = bus.fifo_dout;
        end
      end
      default: ;
    endcase
  end

  // Register the buffer, the in-flight read flag and the delivered-word counter.
  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments, so every register samples pre-edge values.
    if (!resetn) begin
      occ     <= 2'd0;
      pend    <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      // NOTE: both skid entries are reset, not only the valid flag, because entry0 drives out_data directly.
      entry0  <= '0;
      entry1  <= '0;
    end else begin
      occ     <= occ_nxt;
      pend    <= rd;
      valid_q <= (occ_nxt != 2'd0);
      entry0  <= e0_nxt;
      entry1  <= e1_nxt;
      if (xfer) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Structural invariants of the skid buffer and of the pop request.
  a_occ_bound : assert property (@(posedge clk) disable iff (!resetn) occ <= 2'd2);
  a_no_rd_empty : assert property (@(posedge clk) disable iff (!resetn) bus.fifo_rd |-> !bus.fifo_empty);

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain. The FIFO is modelled as a word array with 1-cycle read latency.
// Expected values per cycle are hand-derived tables.
// Inputs change at the falling edge, and outputs are sampled 1 time unit later.
module tb_fifo_drain;

  logic clk;
  logic resetn_tb;
  logic out_ready_tb;
  logic force_empty;
  bit   w_go;

  int n_cmp = 0;
  int n_err = 0;

  // FIFO model: the bench appends words at wr_ptr, and reads pop them at rd_ptr.
  logic [7:0] mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int w_issued = 0;

  fifo_drain_if #(.DATA_WIDTH(8), .CNT_WIDTH(11)) bus ();
  fifo_drain_if #(.DATA_WIDTH(8), .CNT_WIDTH(3))  wbus ();

  fifo_drain #(.DATA_WIDTH(8), .CNT_WIDTH(11)) dut (
    .clk    (clk),
    .resetn (resetn_tb),
    .bus    (bus)
  );

  fifo_drain #(.DATA_WIDTH(8), .CNT_WIDTH(3)) dut_w (
    .clk    (clk),
    .resetn (resetn_tb),
    .bus    (wbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.fifo_empty = force_empty | (rd_ptr == wr_ptr);
  assign bus.out_ready  = out_ready_tb;

  always @(posedge clk) begin
    if (bus.fifo_rd) begin
      bus.fifo_dout <= mem[rd_ptr[5:0]];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  // The second FIFO model returns exactly 9 words, with a sink that is always ready.
  assign wbus.fifo_empty = ~w_go | (w_issued >= 9);
  assign wbus.out_ready  = 1'b1;

  always @(posedge clk) begin
    if (wbus.fifo_rd) begin
      wbus.fifo_dout <= 8'(w_issued);
      w_issued       <= w_issued + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr++;
  endtask

  // One clock cycle: drive inputs, let fifo_rd settle, then compare. A value of -1 means don't care.
  task automatic cycle(input string name, input int idx, input bit rst, input bit rdy, input bit fe,
                       input int e_rd, input int e_v, input int e_d, input int e_occ, input int e_cnt);
    @(negedge clk);
    resetn_tb    = ~rst;
    out_ready_tb = rdy;
    force_empty  = fe;
    #1;
    check($sformatf("%s[%0d] rd_while_empty", name, idx), 32'(bus.fifo_rd & bus.fifo_empty), 32'd0);
    if (e_rd  >= 0) check($sformatf("%s[%0d] fifo_rd", name, idx),     32'(bus.fifo_rd),     32'(e_rd));
    if (e_v   >= 0) check($sformatf("%s[%0d] out_valid", name, idx),   32'(bus.out_valid),   32'(e_v));
    if (e_d   >= 0) check($sformatf("%s[%0d] out_data", name, idx),    32'(bus.out_data),    32'(e_d));
    if (e_occ >= 0) check($sformatf("%s[%0d] occ", name, idx),         32'(dut.occ),         32'(e_occ));
    if (e_cnt >= 0) check($sformatf("%s[%0d] drained_cnt", name, idx), 32'(bus.drained_cnt), 32'(e_cnt));
  endtask

  // Pulse reset for one edge with the FIFO masked, then queue the next test's words.
  task automatic start_test(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] d, input int n);
    @(negedge clk);
    resetn_tb    = 1'b0;
    out_ready_tb = 1'b1;
    force_empty  = 1'b1;
    push(a);
    if (n > 1) push(b);
    if (n > 2) push(c);
    if (n > 3) push(d);
  endtask

  // Streaming: words 0,5,3,6,6 with the sink always ready.
  int s_rd [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
  int s_v  [8] = '{0, 0, 1, 1, 1, 1, 1, 0};
  int s_d  [8] = '{-1, -1, 0, 5, 3, 6, 6, -1};
  int s_cnt[8] = '{0, 0, 0, 1, 2, 3, 4, 5};

  // Back-pressure: words 1,2,3,4 with the sink stalled while word 1 is first shown.
  int b_rdy[10] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
  int b_rd [10] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
  int b_v  [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
  int b_d  [10] = '{-1, -1, 1, 1, 1, 1, 2, 3, 4, -1};
  int b_occ[10] = '{0, 0, 1, 2, 2, 2, 1, 1, 1, 0};
  int b_cnt[10] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 4};

  // Empty gaps: words 7,9,11 with the empty flag toggling every cycle.
  int g_fe [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  int g_rd [8] = '{1, 0, 1, 0, 1, 0, 0, 0};
  int g_v  [8] = '{0, 0, 1, 0, 1, 0, 1, 0};
  int g_d  [8] = '{-1, -1, 7, -1, 9, -1, 11, -1};
  int g_cnt[8] = '{0, 0, 0, 1, 1, 2, 2, 3};

  // Overlap: A=0x10 and B=0x20 are buffered, then the sink releases while C=0x30 is still in flight.
  // The issue rule never lets occ=2 coincide with pend=1.
  // So the closest reachable overlap is this one: B is shown while C arrives, and C is captured as B leaves.
  int o_rdy[7] = '{1, 1, 0, 1, 1, 1, 1};
  int o_rd [7] = '{1, 1, 0, 1, 0, 0, 0};
  int o_v  [7] = '{0, 0, 1, 1, 1, 1, 0};
  int o_d  [7] = '{-1, -1, 16, 16, 32, 48, -1};
  int o_occ[7] = '{0, 0, 1, 2, 1, 1, 0};
  int o_cnt[7] = '{0, 0, 0, 0, 1, 2, 3};

  initial begin
    resetn_tb    = 1'b0;
    out_ready_tb = 1'b1;
    force_empty  = 1'b0;
    push(8'd0); push(8'd5); push(8'd3); push(8'd6); push(8'd6);

    // Reset is held for 3 cycles while the FIFO holds data.
    for (int i = 0; i < 3; i++) cycle("reset", i, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 8; i++)
      cycle("stream", i, 1'b0, 1'b1, 1'b0, s_rd[i], s_v[i], s_d[i], -1, s_cnt[i]);

    start_test(8'd1, 8'd2, 8'd3, 8'd4, 4);
    for (int i = 0; i < 10; i++)
      cycle("bpress", i, 1'b0, b_rdy[i] != 0, 1'b0, b_rd[i], b_v[i], b_d[i], b_occ[i], b_cnt[i]);

    start_test(8'd7, 8'd9, 8'd11, 8'd0, 3);
    for (int i = 0; i < 8; i++)
      cycle("gaps", i, 1'b0, 1'b1, g_fe[i] != 0, g_rd[i], g_v[i], g_d[i], -1, g_cnt[i]);

    start_test(8'h10, 8'h20, 8'h30, 8'h00, 3);
    for (int i = 0; i < 7; i++)
      cycle("overlap", i, 1'b0, o_rdy[i] != 0, 1'b0, o_rd[i], o_v[i], o_d[i], o_occ[i], o_cnt[i]);

    // Reset mid-stream: reset lands while occ=1 and pend=1, and the in-flight word 0x42 must vanish.
    start_test(8'h41, 8'h42, 8'h43, 8'h00, 3);
    cycle("midrst", 0, 1'b0, 1'b1, 1'b0, 1, 0, -1, 0, 0);
    cycle("midrst", 1, 1'b0, 1'b1, 1'b0, 1, 0, -1, 0, 0);
    cycle("midrst", 2, 1'b1, 1'b1, 1'b0, 0, 1, 'h41, 1, 0);
    cycle("midrst", 3, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 0);
    cycle("midrst", 4, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 0);
    cycle("midrst", 5, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 0);

    // Wrap: 9 transfers through a 3-bit counter leave it at 1.
    @(negedge clk);
    w_go = 1'b1;
    repeat (20) @(negedge clk);
    check("wrap pops", 32'(w_issued), 32'd9);
    check("wrap drained_cnt", 32'(wbus.drained_cnt), 32'd1);
    check("wrap out_valid", 32'(wbus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
